alu64_ex_stage: RTL
===================

// Module: alu64_ex_stage
// PURPOSE
//  Registered 64-bit integer execute stage of the RV64 pipeline. Accepts decoded
//  operands + ALU opcode from issue, computes via alu64_comb (OR path uses or64b),
//  and presents result + destination tag to writeback. Valid/ready on both sides,
//  2-entry skid buffer so in_ready is a pure register output (no comb ready path).
// PARAMETERS
//  XLEN      64   datapath width; only 64 is supported
//  TAG_W     5    destination register tag width (rd)
// PORTS
//  clk         in   1      rising-edge clock
//  rst_n       in   1      asynchronous active-low reset
//  in_valid    in   1      upstream holds a valid op
//  in_ready    out  1      stage can accept; registered
//  in_op       in   4      alu_pkg::alu_op_t opcode
//  in_word     in   1      RV64 *W op (OP-32/OP-IMM-32)
//  in_a        in   XLEN   operand A (rs1)
//  in_b        in   XLEN   operand B (rs2 or sign-extended imm)
//  in_rd       in   TAG_W  destination tag, passed through unchanged
//  out_valid   out  1      result valid to writeback
//  out_ready   in   1      writeback accepts this cycle
//  out_result  out  XLEN   computed result
//  out_rd      out  TAG_W  tag matching out_result
// BEHAVIOUR
//  - Reset (async, rst_n=0): out_valid=0, out_result=0, out_rd=0, in_ready=1;
//    both buffer entries invalidated. Reset mid-transfer drops in-flight ops.
//  - Transfer occurs when valid&&ready on a rising edge; latency 1 cycle from
//    input handshake to out_valid when output side is empty.
//  - Buffer: main reg (drives outputs) + skid reg. States EMPTY / ONE / FULL.
//    EMPTY: in accept -> ONE. ONE: accept&!out_ready -> FULL; accept&out_ready
//    -> ONE (main replaced); !accept&out_ready -> EMPTY. FULL: in_ready=0;
//    out_ready -> ONE (skid moves to main). Order is strictly FIFO.
//  - in_ready = (state != FULL), registered; never depends on out_ready comb.
//  - out_result/out_rd stable while out_valid&&!out_ready.
//  - Ops: ADD a+b, SUB a-b (mod 2^64), AND, OR, XOR, SLL/SRL/SRA by b[5:0],
//    SLT signed, SLTU unsigned (result 0 or 1). Undefined opcode -> result 0.
// CONFIGURATION
//  - ALU_WORD_OPS_EN defined: in_word=1 on ADD/SUB/SLL/SRL/SRA computes on a[31:0],
//    b[31:0], shift by b[4:0], result sign-extended from bit 31; in_word ignored
//    for other ops.
//  - Undefined: in_word ignored entirely; all ops are full 64-bit.
// STRUCTURE
//  - alu_pkg: alu_op_t enum (ALU_ADD=0,SUB,AND,OR,XOR,SLL,SRL,SRA,SLT,SLTU),
//    XLEN_DEF, skid state encoding.
//  - Sub-module alu64_comb: purely combinational datapath, instantiates or64b;
//    alu64_ex_stage holds only the handshake/skid logic and registers.
// TESTING
//  - Reset: rst_n=0 mid-FULL -> out_valid=0, in_ready=1 same cycle, no stale result.
//  - OR: a=0x00F0, b=0x0F0F, op=OR, rd=7, out_ready=1 -> next cycle out_valid=1,
//    out_result=0x0FFF, out_rd=7.
//  - Backpressure: out_ready=0, issue 3 back-to-back ADDs (1+1, 2+2, 3+3) -> 2 accepted,
//    in_ready=0; release -> results 2, 4 in order, then 6 accepted.
//  - Signed/shift: SLT a=-1,b=1 -> 1; SLTU same -> 0; SRA a=0x8000_0000_0000_0000,
//    b=4 -> 0xF800_0000_0000_0000.
//  - ALU_WORD_OPS_EN: ADD in_word=1 a=0x7FFF_FFFF,b=1 -> 0xFFFF_FFFF_8000_0000;
//    without macro -> 0x0000_0000_8000_0000.
//  - Random stream with random out_ready vs reference model: zero mismatches, no loss/dup.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the RV64 integer execute stage: ALU opcodes, skid-buffer states
// and a word-result sign-extension helper.
package alu_pkg;

    localparam int XLEN_DEF = 64;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_t;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_t;

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/alu64_comb.sv
// Combinational RV64 ALU datapath (or64b supplies the OR path).
// Optional RV64 *W operations are enabled by defining ALU_WORD_OPS_EN.
module or64b (
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [63:0] y
);
    assign y = a | b;
endmodule

module alu64_comb
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [3:0]      op,
    input  logic            word,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result
);
    logic signed [XLEN-1:0] a_s;
    logic signed [XLEN-1:0] b_s;
    logic [XLEN-1:0]        or_y;
    logic [XLEN-1:0]        full_res;

    assign a_s = a;
    assign b_s = b;

    or64b u_or (
        .a (a),
        .b (b),
        .y (or_y)
    );

    always_comb begin
        full_res = '0;
        case (op)
            ALU_ADD:  full_res = a + b;
            ALU_SUB:  full_res = a - b;
            ALU_AND:  full_res = a & b;
            ALU_OR:   full_res = or_y;
            ALU_XOR:  full_res = a ^ b;
            ALU_SLL:  full_res = a << b[5:0];
            ALU_SRL:  full_res = a >> b[5:0];
            ALU_SRA:  full_res = a_s >>> b[5:0];
            ALU_SLT:  full_res = {{(XLEN-1){1'b0}}, (a_s < b_s)};
            ALU_SLTU: full_res = {{(XLEN-1){1'b0}}, (a < b)};
            default:  full_res = '0;
        endcase
    end

`ifdef ALU_WORD_OPS_EN
    logic signed [31:0] a32_s;
    logic [31:0]        w_res;
    logic               w_hit;

    assign a32_s = a[31:0];

    // *W ops work on the low word only; other opcodes ignore the word flag.
    always_comb begin
        w_res = '0;
        w_hit = 1'b0;
        if (word) begin
            case (op)
                ALU_ADD: begin w_res = a[31:0] + b[31:0];  w_hit = 1'b1; end
                ALU_SUB: begin w_res = a[31:0] - b[31:0];  w_hit = 1'b1; end
                ALU_SLL: begin w_res = a[31:0] << b[4:0];  w_hit = 1'b1; end
                ALU_SRL: begin w_res = a[31:0] >> b[4:0];  w_hit = 1'b1; end
                ALU_SRA: begin w_res = a32_s >>> b[4:0];   w_hit = 1'b1; end
                default: begin w_res = '0;                 w_hit = 1'b0; end
            endcase
        end
    end

    assign result = w_hit ? sext32(w_res) : full_res;
`else
    logic word_unused;
    assign word_unused = word;
    assign result      = full_res;
`endif

endmodule

// File: rtl/alu64_ex_stage.sv
// Registered RV64 execute stage: alu64_comb followed by a 2-entry skid buffer.
// Build option ALU_WORD_OPS_EN enables RV64 *W operations inside alu64_comb.
module alu64_ex_stage
    import alu_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic             in_word,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_rd
);
    skid_state_t      state_q;
    skid_state_t      state_d;
    logic             in_ready_q;
    logic             accept;
    logic             load_main_alu;
    logic             load_main_skid;
    logic             load_skid;
    logic [XLEN-1:0]  alu_res_p0;
    logic [XLEN-1:0]  main_res_p1;
    logic [TAG_W-1:0] main_rd_p1;
    logic [XLEN-1:0]  skid_res_p1;
    logic [TAG_W-1:0] skid_rd_p1;

    // ---- stage p0: combinational execute on the issued operands ----
    alu64_comb #(.XLEN(XLEN)) u_alu (
        .op     (in_op),
        .word   (in_word),
        .a      (in_a),
        .b      (in_b),
        .result (alu_res_p0)
    );

    assign accept = in_valid && in_ready_q;

    always_comb begin
        state_d        = state_q;
        load_main_alu  = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_q)
            SKID_EMPTY: begin
                if (accept) begin
                    state_d       = SKID_ONE;
                    load_main_alu = 1'b1;
                end
            end
            SKID_ONE: begin
                if (accept && !out_ready) begin
                    state_d   = SKID_FULL;
                    load_skid = 1'b1;
                end else if (accept) begin
                    load_main_alu = 1'b1;
                end else if (out_ready) begin
                    state_d = SKID_EMPTY;
                end
            end
            SKID_FULL: begin
                if (out_ready) begin
                    state_d        = SKID_ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: state_d = SKID_EMPTY;
        endcase
    end

    // ---- stage p1: main (output) and skid registers ----
    // in_ready is precomputed from the next state so it never sees out_ready combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= SKID_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != SKID_FULL);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_res_p1 <= '0;
            main_rd_p1  <= '0;
        end else if (load_main_alu) begin
            main_res_p1 <= alu_res_p0;
            main_rd_p1  <= in_rd;
        end else if (load_main_skid) begin
            main_res_p1 <= skid_res_p1;
            main_rd_p1  <= skid_rd_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (load_skid) begin
            skid_res_p1 <= alu_res_p0;
            skid_rd_p1  <= in_rd;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = (state_q != SKID_EMPTY);
    assign out_result = main_res_p1;
    assign out_rd     = main_rd_p1;

endmodule
